// File: rtl/imm_load_encoder_if.sv
// imm_load_encoder_if: request/instruction-stream bundle between the loader, the encoder and instruction memory.
interface imm_load_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [2:0]  in_reg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        out_last;
    logic        busy;
    modport master (
        output in_valid, in_value, in_reg, out_ready,
        input  in_ready, out_valid, out_instr, out_last, busy
    );
    modport slave (
        input  in_valid, in_value, in_reg, out_ready,
        output in_ready, out_valid, out_instr, out_last, busy
    );
endinterface

// File: rtl/imm_load_encoder.sv
// imm_load_encoder: streams LI/SLL/ADDIU words that rebuild a 16-bit constant in a register.
// Define IMM_LOAD_ENCODER_SHORT_EN to emit the shortest 1-3 word sequence instead of always three.
module imm_load_encoder (
    input logic clk,
    input logic rst,
    imm_load_encoder_if.slave bus
);
    localparam logic [4:0] OP_LI    = 5'b01101;
    localparam logic [4:0] OP_SLL   = 5'b00110;
    localparam logic [4:0] OP_ADDIU = 5'b01001;
    typedef enum logic [1:0] {IDLE, LI, SLL, ADDIU} state_t;
    state_t state;
    logic [7:0] lo;
    logic [2:0] r;
    logic has_sll, has_addiu;
    logic [7:0] li_imm;
    logic pick_sll, pick_addiu;
    logic hs;
    logic [7:0] h;
    assign hs = bus.out_valid && bus.out_ready;
    // Rounding the high byte up when bit 7 is set cancels ADDIU's sign extension.
    assign h = bus.in_value[15:8] + {7'd0, bus.in_value[7]};
    assign bus.in_ready = state == IDLE;
    assign bus.busy = state != IDLE;
    assign bus.out_valid = state != IDLE;
`ifdef IMM_LOAD_ENCODER_SHORT_EN
    logic hi_zero, neg_byte, lo_zero;
    assign hi_zero = bus.in_value[15:8] == 8'h00;
    assign neg_byte = &bus.in_value[15:7];
    assign lo_zero = bus.in_value[7:0] == 8'h00;
    always_comb begin
        li_imm = hi_zero ? bus.in_value[7:0] : neg_byte ? 8'h00 : lo_zero ? bus.in_value[15:8] : h;
        pick_sll = !hi_zero && !neg_byte;
        pick_addiu = !hi_zero && (neg_byte || !lo_zero);
    end
`else
    always_comb begin
        li_imm = h;
        pick_sll = 1'b1;
        pick_addiu = 1'b1;
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bus.out_instr <= 16'h0000;
            bus.out_last <= 1'b0;
            lo <= 8'h00;
            r <= 3'd0;
            has_sll <= 1'b0;
            has_addiu <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state <= LI;
                    r <= bus.in_reg;
                    lo <= bus.in_value[7:0];
                    has_sll <= pick_sll;
                    has_addiu <= pick_addiu;
                    bus.out_instr <= {OP_LI, bus.in_reg, li_imm};
                    bus.out_last <= !pick_sll && !pick_addiu;
                end
                LI: if (hs) begin
                    if (has_sll) begin
                        state <= SLL;
                        bus.out_instr <= {OP_SLL, r, r, 5'b00000};
                        bus.out_last <= !has_addiu;
                    end else if (has_addiu) begin
                        state <= ADDIU;
                        bus.out_instr <= {OP_ADDIU, r, lo};
                        bus.out_last <= 1'b1;
                    end else begin
                        state <= IDLE;
                        bus.out_instr <= 16'h0000;
                        bus.out_last <= 1'b0;
                    end
                end
                SLL: if (hs) begin
                    state <= has_addiu ? ADDIU : IDLE;
                    bus.out_instr <= has_addiu ? {OP_ADDIU, r, lo} : 16'h0000;
                    bus.out_last <= has_addiu;
                end
                default: if (hs) begin
                    state <= IDLE;
                    bus.out_instr <= 16'h0000;
                    bus.out_last <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imm_load_encoder.sv
// tb_imm_load_encoder: directed scoreboard bench for imm_load_encoder (either IMM_LOAD_ENCODER_SHORT_EN build).
module tb_imm_load_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int chk = 0;
    int fails = 0;
    logic [16:0] exp_q[$];
    imm_load_encoder_if bus();
    imm_load_encoder dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] instr, input logic last);
        exp_q.push_back({last, instr});
    endtask

    function automatic logic [15:0] li_w(input logic [2:0] r, input logic [7:0] imm);
        return {5'b01101, r, imm};
    endfunction
    function automatic logic [15:0] sll_w(input logic [2:0] r);
        return {5'b00110, r, r, 5'b00000};
    endfunction
    function automatic logic [15:0] ad_w(input logic [2:0] r, input logic [7:0] imm);
        return {5'b01001, r, imm};
    endfunction

    task automatic push_model(input logic [15:0] v, input logic [2:0] r);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = v[15:8];
        lo = v[7:0];
`ifdef IMM_LOAD_ENCODER_SHORT_EN
        if (hi == 8'h00) begin
            push(li_w(r, lo), 1'b1);
            return;
        end
        if (v[15:7] == 9'h1FF) begin
            push(li_w(r, 8'h00), 1'b0);
            push(ad_w(r, lo), 1'b1);
            return;
        end
        if (lo == 8'h00) begin
            push(li_w(r, hi), 1'b0);
            push(sll_w(r), 1'b1);
            return;
        end
`endif
        push(li_w(r, v[7] ? hi + 8'd1 : hi), 1'b0);
        push(sll_w(r), 1'b0);
        push(ad_w(r, lo), 1'b1);
    endtask

    task automatic accept(input logic [15:0] v, input logic [2:0] r);
        @(negedge clk);
        check("idle_in_ready", {15'd0, bus.in_ready}, 16'd1);
        check("idle_out_valid", {15'd0, bus.out_valid}, 16'd0);
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_reg = r;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_value = 16'($urandom);
        bus.in_reg = 3'($urandom);
    endtask

    // Pops up to max_words handshaken words; stalls 3 cycles on word stall_idx.
    task automatic consume(input int stall_idx, input int max_words);
        int idx = 0;
        int held = 0;
        int guard = 0;
        while (exp_q.size() > 0 && idx < max_words && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus.out_valid) begin
                if (idx == stall_idx && held < 3) begin
                    bus.out_ready = 1'b0;
                    check("stall_instr", bus.out_instr, exp_q[0][15:0]);
                    check("stall_last", {15'd0, bus.out_last}, {15'd0, exp_q[0][16]});
                    held++;
                end else begin
                    bus.out_ready = 1'b1;
                    check("instr", bus.out_instr, exp_q[0][15:0]);
                    check("last", {15'd0, bus.out_last}, {15'd0, exp_q[0][16]});
                    void'(exp_q.pop_front());
                    idx++;
                end
            end
        end
        bus.out_ready = 1'b1;
        check("words_seen", 16'(idx), 16'(idx < max_words ? idx + exp_q.size() : max_words));
    endtask

    task automatic run(input logic [15:0] v, input logic [2:0] r, input int stall_idx);
        accept(v, r);
        consume(stall_idx, 3);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_value = 16'h0000;
        bus.in_reg = 3'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_out_instr", bus.out_instr, 16'h0000);
        check("rst_out_last", {15'd0, bus.out_last}, 16'd0);
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        check("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        rst = 1'b0;
`ifdef IMM_LOAD_ENCODER_SHORT_EN
        push(16'h6B42, 1'b1);
        run(16'h0042, 3'd3, -1);
        push(16'h6900, 1'b0);
        push(16'h49F0, 1'b1);
        run(16'hFFF0, 3'd1, -1);
        push(16'h6A12, 1'b0);
        push(16'h3240, 1'b1);
        run(16'h1200, 3'd2, -1);
`else
        push(16'h6B00, 1'b0);
        push(16'h3360, 1'b0);
        push(16'h4B42, 1'b1);
        run(16'h0042, 3'd3, -1);
        push(16'h6800, 1'b0);
        push(16'h3000, 1'b0);
        push(16'h4880, 1'b1);
        run(16'hFF80, 3'd0, -1);
`endif
        push(16'h6813, 1'b0);
        push(16'h3000, 1'b0);
        push(16'h48F0, 1'b1);
        run(16'h12F0, 3'd0, 1);
        push_model(16'h0000, 3'd7);
        run(16'h0000, 3'd7, -1);
        push_model(16'hFFFF, 3'd5);
        run(16'hFFFF, 3'd5, 0);
        push_model(16'h007F, 3'd4);
        run(16'h007F, 3'd4, -1);
        push_model(16'h0080, 3'd6);
        run(16'h0080, 3'd6, 2);
        push_model(16'hFF7F, 3'd2);
        run(16'hFF7F, 3'd2, -1);
        push_model(16'h8000, 3'd1);
        run(16'h8000, 3'd1, -1);
        push_model(16'h5A5A, 3'd3);
        run(16'h5A5A, 3'd3, -1);
        push_model(16'h12F0, 3'd0);
        accept(16'h12F0, 3'd0);
        consume(-1, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("abort_out_instr", bus.out_instr, 16'h0000);
        check("abort_out_last", {15'd0, bus.out_last}, 16'd0);
        check("abort_in_ready", {15'd0, bus.in_ready}, 16'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
`ifdef IMM_LOAD_ENCODER_SHORT_EN
        push(16'h6801, 1'b1);
`else
        push(16'h6800, 1'b0);
        push(16'h3000, 1'b0);
        push(16'h4801, 1'b1);
`endif
        run(16'h0001, 3'd0, -1);
        @(negedge clk);
        check("final_idle", {15'd0, bus.busy}, 16'd0);
        check("final_no_extra", {15'd0, bus.out_valid}, 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end
endmodule

// File: doc/imm_load_encoder.md
# imm_load_encoder

Turns a 16-bit constant and a destination register into the 16-bit instruction words (LI / SLL / ADDIU) that rebuild that constant in the register. It is the inverse of the decode-side immediate extension: it produces the 8-bit zero-extended LI field, the 3-bit SLL shift field (000 means 8) and the 8-bit sign-extended ADDIU field. It sits between the boot/monitor loader and instruction memory and streams one instruction word per cycle over a valid/ready handshake.

## Interface
- No parameters. Word width is fixed at 16 bits and the register field at 3 bits.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept a request; high only in IDLE
- in_value  in  16  constant to materialise
- in_reg  in  3  destination register rx
- out_valid  out  1  out_instr holds a valid word
- out_ready  in  1  consumer accepts the word
- out_instr  out  16  encoded instruction
- out_last  out  1  current word is the last of its sequence
- busy  out  1  high when the state is not IDLE

## Operation
- A request is accepted on a clock edge where in_valid && in_ready are both high. At that edge the block latches V = in_value and R = in_reg.
- Instruction encodings:
  - LI: {5'b01101, R, imm8}
  - SLL: {5'b00110, R, R, 3'b000, 2'b00}, a shift by 8
  - ADDIU: {5'b01001, R, imm8}, where imm8 is sign-extended by the core
- Full sequence:
  - LI R, H where H = (V[15:8] + V[7]) mod 256
  - SLL R, R, 8
  - ADDIU R, V[7:0]
  - This is exact for every V. The wrap case H = 0xFF+1 = 0x00 gives sext(lo), which is correct.
- Short sequences (only with the macro, see Configuration). The first rule that matches wins:
  1. V[15:8] == 0: LI R, V[7:0] (1 word)
  2. V[15:7] all ones: LI R, 0x00; ADDIU R, V[7:0] (2 words)
  3. V[7:0] == 0: LI R, V[15:8]; SLL (2 words)
  4. Otherwise: the full 3-word sequence
- States and transitions:
  - IDLE -> LI on accept.
  - LI -> SLL, ADDIU or IDLE on an out handshake, depending on the chosen sequence.
  - SLL -> ADDIU or IDLE on an out handshake.
  - ADDIU -> IDLE on an out handshake.
  - No state advances without the handshake out_valid && out_ready.
- out_instr and out_last are registered. They are loaded on entry to each emit state.
- out_last is high exactly on the final word of a sequence.

## Timing
- Reset values:
  - state = IDLE
  - out_valid = 0, out_instr = 16'h0000, out_last = 0
  - busy = 0, in_ready = 1
- Latency: the first word is valid in the cycle after the accept edge.
- Throughput: one word per cycle while out_ready is held high. There is one IDLE cycle between requests, so in_ready rises the cycle after the last handshake.
- Backpressure: while out_valid && !out_ready, out_instr, out_last and the state are held stable.
- Since in_ready is low outside IDLE, a new request can never coincide with an in-flight sequence.
- in_value and in_reg are ignored except on the accept edge.
- rst asserted mid-sequence aborts at once: the state goes to IDLE and outputs take their reset values. No partial sequence is resumed after reset.
- out_valid never drops until its word has been handshaken.

## Configuration
- IMM_LOAD_ENCODER_SHORT_EN
  - Defined: rules 1–4 select the shortest sequence.
  - Undefined: every request emits the full 3-word LI/SLL/ADDIU sequence. This includes ADDIU R, 0x00 when V[7:0] = 0.

## Test plan
- Macro defined, V=0x0042, R=3: one word 0x6B42 with out_last=1; in_ready high again 2 cycles after accept.
- Macro defined, V=0xFFF0, R=1: 0x6900 then 0x49F0 (last).
- Macro defined, V=0x1200, R=2: 0x6A12 then 0x3240 (last).
- V=0x12F0, R=0: 0x6813, 0x3000, 0x48F0 (last).
  - Hold out_ready low for 3 cycles while 0x3000 is presented; it must stay stable and nothing may be skipped or duplicated.
- Macro undefined, V=0x0042, R=3: 0x6B00, 0x3360, 0x4B42 (last).
  - V=0xFF80, R=0: 0x6800, 0x3000, 0x4880, which rebuilds 0xFF80.
- Reset edge cases:
  - Assert rst after the first word of V=0x12F0: out_valid=0, out_instr=0x0000 and in_ready=1 immediately.
  - A following request for V=0x0001, R=0 then yields only 0x6801 (macro defined).
